ahb2apb_bridge_mslv: RTL and testbench

Parametrised AHB-Lite to APB3 bridge: the next generation of the team's fixed 3-slave AHB2APB bridge.
- Generalises slave count, address/data width and address map.
- Adds APB3 PREADY wait states, PSLVERR propagation and AHB two-cycle ERROR responses for decode misses.
- Sits between the AHB-Lite interconnect (slave port) and up to NUM_SLV APB peripherals; per-slave return buses are muxed internally.

---
 rtl/ahb2apb_bridge_mslv.sv | 214 +++++++++++++++++++++
 tb/tb_ahb2apb_bridge_mslv.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge_mslv.sv
// AHB-Lite to APB3 bridge for up to NUM_SLV peripherals in equal power-of-two windows from SLV_BASE.
// Latency: read reaches Penable 2 cycles after the accepted address phase, write 3 cycles; PREADY adds waits.
// Backpressure: Hreadyout low through WDATA/SETUP/ACCESS and ERR1; optional ACCESS watchdog under APB_TIMEOUT_EN.
module ahb2apb_bridge_mslv #(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                NUM_SLV       = 3,
  parameter logic [ADDR_W-1:0] SLV_BASE      = 'h8000_0000,
  parameter int                SLV_SIZE_LOG2 = 26,
  parameter int                TIMEOUT_CYC   = 256
) (
  input  logic                      Hclk,
  input  logic                      Hreset,
  input  logic                      Hwrite,
  input  logic                      Hreadyin,
  input  logic [1:0]                Htrans,
  input  logic [ADDR_W-1:0]         Haddr,
  input  logic [DATA_W-1:0]         Hwdata,
  input  logic [NUM_SLV*DATA_W-1:0] Prdata,
  input  logic [NUM_SLV-1:0]        Pready,
  input  logic [NUM_SLV-1:0]        Pslverr,
  output logic [NUM_SLV-1:0]        Pselx,
  output logic [ADDR_W-1:0]         Paddr,
  output logic [DATA_W-1:0]         Pwdata,
  output logic                      Pwrite,
  output logic                      Penable,
  output logic                      Hreadyout,
  output logic [1:0]                Hresp,
  output logic [DATA_W-1:0]         Hrdata
);

  localparam int SLOT_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;

  logic [ADDR_W-1:0]   addr_off;
  logic [ADDR_W-1:0]   slot_full;
  logic                dec_hit;
  logic [SLOT_W-1:0]   dec_slot;
  logic                accept_req;
  logic                take;
  logic                psel_active;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_rdy;
  logic                sel_err;
  logic                wdog_exp;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] wdog_q, wdog_d;

  // Watchdog flags the last tolerated wait cycle; Pready in that same cycle still completes normally.
  assign wdog_exp = (wdog_q == CNT_W'(TIMEOUT_CYC - 1));

  // Count ACCESS wait cycles; SETUP always precedes ACCESS, so clearing there clears on ACCESS entry.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_SETUP) begin
      wdog_d = '0;
    end else if (state_q == S_ACCESS && !sel_rdy) begin
      wdog_d = wdog_q + CNT_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_exp = 1'b0;
`endif

  // A transfer is requested for NONSEQ/SEQ with the bus ready; IDLE/BUSY are ignored.
  assign accept_req = Hreadyin && (Htrans inside {2'b10, 2'b11});

  // Address decode: equal windows above SLV_BASE; anything below the base or past the last slot misses.
  always_comb begin
    addr_off  = Haddr - SLV_BASE;
    slot_full = addr_off >> SLV_SIZE_LOG2;
    dec_hit   = (Haddr >= SLV_BASE) && (slot_full < ADDR_W'(NUM_SLV));
    dec_slot  = slot_full[SLOT_W-1:0];
  end

  // Return-path mux: pick the active slave's PRDATA/PREADY/PSLVERR.
  always_comb begin
    sel_rdata = '0;
    sel_rdy   = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        sel_rdata = Prdata[i*DATA_W +: DATA_W];
        sel_rdy   = Pready[i];
        sel_err   = Pslverr[i];
      end
    end
  end

  // FSM next state, AHB response and APB control; a new transfer may start in IDLE or a clean ACCESS completion.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    take        = 1'b0;
    psel_active = 1'b0;
    Penable     = 1'b0;
    Hreadyout   = 1'b1;
    Hresp       = 2'b00;

    case (state_q)
      S_IDLE: begin
        take = accept_req;
      end
      S_WDATA: begin
        Hreadyout = 1'b0;
        pwdata_d  = Hwdata;
        state_d   = S_SETUP;
      end
      S_SETUP: begin
        Hreadyout   = 1'b0;
        psel_active = 1'b1;
        state_d     = S_ACCESS;
      end
      S_ACCESS: begin
        psel_active = 1'b1;
        Penable     = 1'b1;
        Hreadyout   = sel_rdy && !sel_err;
        if (sel_rdy) begin
          if (sel_err) begin
            state_d = S_ERR1;
          end else begin
            state_d = S_IDLE;
            take    = accept_req;
          end
        end else if (wdog_exp) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1: begin
        Hreadyout = 1'b0;
        Hresp     = 2'b01;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        Hresp   = 2'b01;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Misses go straight to the error response without touching the APB side.
    if (take) begin
      if (dec_hit) begin
        slot_d   = dec_slot;
        paddr_d  = Haddr;
        pwrite_d = Hwrite;
        state_d  = Hwrite ? S_WDATA : S_SETUP;
      end else begin
        state_d = S_ERR1;
      end
    end
  end

  // State and APB address/data registers; APB fields hold their values when idle.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
    end
  end

  // One-hot select of the latched slot while in SETUP/ACCESS.
  always_comb begin
    Pselx = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      Pselx[i] = psel_active && (slot_q == SLOT_W'(i));
    end
  end

  assign Paddr  = paddr_q;
  assign Pwrite = pwrite_q;
  assign Pwdata = pwdata_q;
  assign Hrdata = Penable ? sel_rdata : '0;

endmodule

// File: tb/tb_ahb2apb_bridge_mslv.sv
module tb_ahb2apb_bridge_mslv;

  logic        Hclk = 1'b0;
  logic        Hreset = 1'b1;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [95:0] Prdata;
  logic [2:0]  Pready;
  logic [2:0]  Pslverr;
  logic [2:0]  Pselx;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Pwrite;
  logic        Penable;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] AD_A = 32'h8400_0010;
  localparam logic [31:0] AD_B = 32'h8800_0004;
  localparam logic [31:0] AD_C = 32'h8000_0020;
  localparam logic [31:0] AD_D = 32'h8C00_0000;
  localparam logic [31:0] AD_E = 32'h8800_0100;
  localparam logic [31:0] RD0  = 32'h0000_AAAA;
  localparam logic [31:0] RD1  = 32'hDEAD_BEEF;
  localparam logic [31:0] RD2  = 32'h2222_2222;

  always #5 Hclk = ~Hclk;

  // Single-slave AHB system: the bridge's own HREADYOUT is the global HREADY.
  assign Hreadyin = Hreadyout;

  ahb2apb_bridge_mslv #(.TIMEOUT_CYC(4)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .Pready(Pready), .Pslverr(Pslverr), .Pselx(Pselx), .Paddr(Paddr),
    .Pwdata(Pwdata), .Pwrite(Pwrite), .Penable(Penable),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
  );

  typedef struct {
    string       nm;
    logic        hw;
    logic [1:0]  ht;
    logic [31:0] ha;
    logic [31:0] hd;
    logic [2:0]  rdy;
    logic [2:0]  err;
    logic [2:0]  e_psel;
    logic        e_pen;
    logic        e_pwr;
    logic [31:0] e_pa;
    logic [31:0] e_pwd;
    logic        e_hrdy;
    logic [1:0]  e_hresp;
    logic [31:0] e_hrd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic hw, input logic [1:0] ht,
                     input logic [31:0] ha, input logic [31:0] hd,
                     input logic [2:0] rdy, input logic [2:0] err,
                     input logic [2:0] psel, input logic pen, input logic pwr,
                     input logic [31:0] pa, input logic [31:0] pwd,
                     input logic hrdy, input logic [1:0] hresp, input logic [31:0] hrd);
    vec_t v;
    v.nm = nm; v.hw = hw; v.ht = ht; v.ha = ha; v.hd = hd; v.rdy = rdy; v.err = err;
    v.e_psel = psel; v.e_pen = pen; v.e_pwr = pwr; v.e_pa = pa; v.e_pwd = pwd;
    v.e_hrdy = hrdy; v.e_hresp = hresp; v.e_hrd = hrd;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input vec_t v);
    chk({v.nm, ".Pselx"},     32'(Pselx),     32'(v.e_psel));
    chk({v.nm, ".Penable"},   32'(Penable),   32'(v.e_pen));
    chk({v.nm, ".Pwrite"},    32'(Pwrite),    32'(v.e_pwr));
    chk({v.nm, ".Paddr"},     Paddr,          v.e_pa);
    chk({v.nm, ".Pwdata"},    Pwdata,         v.e_pwd);
    chk({v.nm, ".Hreadyout"}, 32'(Hreadyout), 32'(v.e_hrdy));
    chk({v.nm, ".Hresp"},     32'(Hresp),     32'(v.e_hresp));
    chk({v.nm, ".Hrdata"},    Hrdata,         v.e_hrd);
  endtask

  // Each vector is one clock: inputs driven just after the edge, outputs sampled at the falling edge.
  task automatic run_vecs();
    foreach (vq[k]) begin
      @(posedge Hclk);
      #1;
      Hwrite  = vq[k].hw;
      Htrans  = vq[k].ht;
      Haddr   = vq[k].ha;
      Hwdata  = vq[k].hd;
      Pready  = vq[k].rdy;
      Pslverr = vq[k].err;
      @(negedge Hclk);
      check_outputs(vq[k]);
    end
    vq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t rstv;
    Hwrite = 1'b0; Htrans = 2'b00; Haddr = '0; Hwdata = '0;
    Prdata = {RD2, RD1, RD0}; Pready = 3'b111; Pslverr = 3'b000;

    rstv.nm = "reset"; rstv.hw = 0; rstv.ht = 0; rstv.ha = 0; rstv.hd = 0;
    rstv.rdy = 3'b111; rstv.err = 0; rstv.e_psel = 0; rstv.e_pen = 0; rstv.e_pwr = 0;
    rstv.e_pa = 0; rstv.e_pwd = 0; rstv.e_hrdy = 1; rstv.e_hresp = 0; rstv.e_hrd = 0;

    repeat (2) @(negedge Hclk);
    check_outputs(rstv);
    Hreset = 1'b0;

    //   name        hw ht     haddr  hwdata         rdy     err     psel    pen pwr paddr pwdata         hrdy hresp  hrdata
    // zero-wait read of slot 1
    add("rd_acc",    0, 2'd2, AD_A,  0,             3'b111, 3'b000, 3'b000, 0, 0, 0,    0,             1, 2'b00, 0);
    add("rd_setup",  0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b010, 0, 0, AD_A, 0,             0, 2'b00, 0);
    add("rd_access", 0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b010, 1, 0, AD_A, 0,             1, 2'b00, RD1);
    add("rd_idle",   0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b000, 0, 0, AD_A, 0,             1, 2'b00, 0);
    // zero-wait write of slot 2; address-phase Hwdata must not be captured
    add("wr_acc",    1, 2'd2, AD_B,  32'hFFFF_0000, 3'b111, 3'b000, 3'b000, 0, 0, AD_A, 0,             1, 2'b00, 0);
    add("wr_wdata",  0, 2'd0, 0,     32'h1234_5678, 3'b111, 3'b000, 3'b000, 0, 1, AD_B, 0,             0, 2'b00, 0);
    add("wr_setup",  0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b100, 0, 1, AD_B, 32'h1234_5678, 0, 2'b00, 0);
    add("wr_access", 0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b100, 1, 1, AD_B, 32'h1234_5678, 1, 2'b00, RD2);
    add("wr_idle",   0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b000, 0, 1, AD_B, 32'h1234_5678, 1, 2'b00, 0);
    // read slot 0 with three wait states
    add("ws_acc",    0, 2'd2, AD_C,  0,             3'b111, 3'b000, 3'b000, 0, 1, AD_B, 32'h1234_5678, 1, 2'b00, 0);
    add("ws_setup",  0, 2'd0, 0,     0,             3'b110, 3'b000, 3'b001, 0, 0, AD_C, 32'h1234_5678, 0, 2'b00, 0);
    add("ws_wait1",  0, 2'd0, 0,     0,             3'b110, 3'b000, 3'b001, 1, 0, AD_C, 32'h1234_5678, 0, 2'b00, RD0);
    add("ws_wait2",  0, 2'd0, 0,     0,             3'b110, 3'b000, 3'b001, 1, 0, AD_C, 32'h1234_5678, 0, 2'b00, RD0);
    add("ws_wait3",  0, 2'd0, 0,     0,             3'b110, 3'b000, 3'b001, 1, 0, AD_C, 32'h1234_5678, 0, 2'b00, RD0);
    add("ws_done",   0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b001, 1, 0, AD_C, 32'h1234_5678, 1, 2'b00, RD0);
    add("ws_idle",   0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b000, 0, 0, AD_C, 32'h1234_5678, 1, 2'b00, 0);
    // decode miss; a request during ERR2 is ignored
    add("ms_acc",    0, 2'd2, AD_D,  0,             3'b111, 3'b000, 3'b000, 0, 0, AD_C, 32'h1234_5678, 1, 2'b00, 0);
    add("ms_err1",   0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b000, 0, 0, AD_C, 32'h1234_5678, 0, 2'b01, 0);
    add("ms_err2",   0, 2'd2, AD_A,  0,             3'b111, 3'b000, 3'b000, 0, 0, AD_C, 32'h1234_5678, 1, 2'b01, 0);
    add("ms_idle",   0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b000, 0, 0, AD_C, 32'h1234_5678, 1, 2'b00, 0);
    // slot 2 write answered with PSLVERR
    add("se_acc",    1, 2'd2, AD_E,  0,             3'b111, 3'b000, 3'b000, 0, 0, AD_C, 32'h1234_5678, 1, 2'b00, 0);
    add("se_wdata",  0, 2'd0, 0,     32'hCAFE_0001, 3'b111, 3'b000, 3'b000, 0, 1, AD_E, 32'h1234_5678, 0, 2'b00, 0);
    add("se_setup",  0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b100, 0, 1, AD_E, 32'hCAFE_0001, 0, 2'b00, 0);
    add("se_access", 0, 2'd0, 0,     0,             3'b111, 3'b100, 3'b100, 1, 1, AD_E, 32'hCAFE_0001, 0, 2'b00, RD2);
    add("se_err1",   0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b000, 0, 1, AD_E, 32'hCAFE_0001, 0, 2'b01, 0);
    add("se_err2",   0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b000, 0, 1, AD_E, 32'hCAFE_0001, 1, 2'b01, 0);
    // back-to-back read, write, read
    add("bb_acc1",   0, 2'd2, AD_A,  0,             3'b111, 3'b000, 3'b000, 0, 1, AD_E, 32'hCAFE_0001, 1, 2'b00, 0);
    add("bb_setup1", 1, 2'd2, AD_B,  0,             3'b111, 3'b000, 3'b010, 0, 0, AD_A, 32'hCAFE_0001, 0, 2'b00, 0);
    add("bb_acc2",   1, 2'd2, AD_B,  0,             3'b111, 3'b000, 3'b010, 1, 0, AD_A, 32'hCAFE_0001, 1, 2'b00, RD1);
    add("bb_wdata2", 0, 2'd2, AD_C,  32'h5555_AAAA, 3'b111, 3'b000, 3'b000, 0, 1, AD_B, 32'hCAFE_0001, 0, 2'b00, 0);
    add("bb_setup2", 0, 2'd2, AD_C,  0,             3'b111, 3'b000, 3'b100, 0, 1, AD_B, 32'h5555_AAAA, 0, 2'b00, 0);
    add("bb_acc3",   0, 2'd2, AD_C,  0,             3'b111, 3'b000, 3'b100, 1, 1, AD_B, 32'h5555_AAAA, 1, 2'b00, RD2);
    add("bb_setup3", 0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b001, 0, 0, AD_C, 32'h5555_AAAA, 0, 2'b00, 0);
    add("bb_access3",0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b001, 1, 0, AD_C, 32'h5555_AAAA, 1, 2'b00, RD0);
    add("bb_idle",   0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b000, 0, 0, AD_C, 32'h5555_AAAA, 1, 2'b00, 0);
    // BUSY transfer is ignored
    add("busy",      0, 2'd1, AD_A,  0,             3'b111, 3'b000, 3'b000, 0, 0, AD_C, 32'h5555_AAAA, 1, 2'b00, 0);
    add("busy_idle", 0, 2'd0, 0,     0,             3'b111, 3'b000, 3'b000, 0, 0, AD_C, 32'h5555_AAAA, 1, 2'b00, 0);
    run_vecs();

    // Reset asserted mid-ACCESS must clear outputs without waiting for a clock edge.
    @(posedge Hclk); #1;
    Hwrite = 1'b0; Htrans = 2'd2; Haddr = AD_A; Pready = 3'b101;
    @(posedge Hclk); #1;
    Htrans = 2'd0; Haddr = '0;
    @(posedge Hclk); #1;
    chk("rst_pre.Penable", 32'(Penable), 32'd1);
    chk("rst_pre.Pselx", 32'(Pselx), 32'(3'b010));
    #1 Hreset = 1'b1;
    #1 check_outputs(rstv);
    @(negedge Hclk);
    Hreset = 1'b0;
    Pready = 3'b111;

`ifdef APB_TIMEOUT_EN
    // Pready stuck low on slot 1: four ACCESS cycles, then ERROR.
    add("to_acc",    0, 2'd2, AD_A,  0, 3'b111, 3'b000, 3'b000, 0, 0, 0,    0, 1, 2'b00, 0);
    add("to_setup",  0, 2'd0, 0,     0, 3'b101, 3'b000, 3'b010, 0, 0, AD_A, 0, 0, 2'b00, 0);
    add("to_wait1",  0, 2'd0, 0,     0, 3'b101, 3'b000, 3'b010, 1, 0, AD_A, 0, 0, 2'b00, RD1);
    add("to_wait2",  0, 2'd0, 0,     0, 3'b101, 3'b000, 3'b010, 1, 0, AD_A, 0, 0, 2'b00, RD1);
    add("to_wait3",  0, 2'd0, 0,     0, 3'b101, 3'b000, 3'b010, 1, 0, AD_A, 0, 0, 2'b00, RD1);
    add("to_wait4",  0, 2'd0, 0,     0, 3'b101, 3'b000, 3'b010, 1, 0, AD_A, 0, 0, 2'b00, RD1);
    add("to_err1",   0, 2'd0, 0,     0, 3'b101, 3'b000, 3'b000, 0, 0, AD_A, 0, 0, 2'b01, 0);
    add("to_err2",   0, 2'd0, 0,     0, 3'b111, 3'b000, 3'b000, 0, 0, AD_A, 0, 1, 2'b01, 0);
    add("to_idle",   0, 2'd0, 0,     0, 3'b111, 3'b000, 3'b000, 0, 0, AD_A, 0, 1, 2'b00, 0);
    // Pready arriving in the expiry cycle completes normally.
    add("tw_acc",    0, 2'd2, AD_A,  0, 3'b111, 3'b000, 3'b000, 0, 0, AD_A, 0, 1, 2'b00, 0);
    add("tw_setup",  0, 2'd0, 0,     0, 3'b101, 3'b000, 3'b010, 0, 0, AD_A, 0, 0, 2'b00, 0);
    add("tw_wait1",  0, 2'd0, 0,     0, 3'b101, 3'b000, 3'b010, 1, 0, AD_A, 0, 0, 2'b00, RD1);
    add("tw_wait2",  0, 2'd0, 0,     0, 3'b101, 3'b000, 3'b010, 1, 0, AD_A, 0, 0, 2'b00, RD1);
    add("tw_wait3",  0, 2'd0, 0,     0, 3'b101, 3'b000, 3'b010, 1, 0, AD_A, 0, 0, 2'b00, RD1);
    add("tw_done",   0, 2'd0, 0,     0, 3'b111, 3'b000, 3'b010, 1, 0, AD_A, 0, 1, 2'b00, RD1);
    add("tw_idle",   0, 2'd0, 0,     0, 3'b111, 3'b000, 3'b000, 0, 0, AD_A, 0, 1, 2'b00, 0);
`else
    // Without the watchdog a long wait just holds ACCESS.
    add("lw_acc",    0, 2'd2, AD_A,  0, 3'b111, 3'b000, 3'b000, 0, 0, 0,    0, 1, 2'b00, 0);
    add("lw_setup",  0, 2'd0, 0,     0, 3'b101, 3'b000, 3'b010, 0, 0, AD_A, 0, 0, 2'b00, 0);
    for (int i = 0; i < 8; i++)
      add("lw_wait", 0, 2'd0, 0,     0, 3'b101, 3'b000, 3'b010, 1, 0, AD_A, 0, 0, 2'b00, RD1);
    add("lw_done",   0, 2'd0, 0,     0, 3'b111, 3'b000, 3'b010, 1, 0, AD_A, 0, 1, 2'b00, RD1);
    add("lw_idle",   0, 2'd0, 0,     0, 3'b111, 3'b000, 3'b000, 0, 0, AD_A, 0, 1, 2'b00, 0);
`endif
    run_vecs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
